axi4_id_compactor: RTL and testbench



---
 rtl/axi4_id_compactor_pkg.sv | 18 +
 rtl/axi4_id_map_table.sv | 87 ++++++++
 rtl/axi4_id_compactor.sv | 109 ++++++++++
 tb/tb_axi4_id_compactor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_id_compactor_pkg.sv
// Shared slot record and slot-count helper for the AXI4 ID compactor.
// Slot fields are stored at a fixed maximum width; tables zero-extend narrower IDs/counts.
package axi4_id_compactor_pkg;

   localparam int SLOT_ID_W  = 16;
   localparam int SLOT_CNT_W = 8;

   typedef struct packed {
      logic                  valid;
      logic [SLOT_ID_W-1:0]  in_id;
      logic [SLOT_CNT_W-1:0] cnt;
   } slot_t;

   function automatic int nslot(input int out_id_w);
      return 1 << out_id_w;
   endfunction

endpackage

// File: rtl/axi4_id_map_table.sv
// One ID remap table: combinational lookup/response-ID restore, registered allocate/retire.
// 0-cycle lookup; o_req_can drops when the hit slot is at max or no slot is free.
module axi4_id_map_table
   import axi4_id_compactor_pkg::*;
#(
   parameter int IN_ID_W  = 8,
   parameter int OUT_ID_W = 2,
   parameter int CNT_W    = 4
) (
   input  logic                i_core_clk,
   input  logic                i_arst_n,
   input  logic                i_req_fire,
   input  logic [IN_ID_W-1:0]  i_req_id,
   output logic                o_req_can,
   output logic [OUT_ID_W-1:0] o_req_slot,
   input  logic                i_ret,
   input  logic [OUT_ID_W-1:0] i_rsp_slot,
   output logic [IN_ID_W-1:0]  o_rsp_id,
   output logic                o_err
);

   localparam int NSLOT = nslot(OUT_ID_W);
   localparam logic [SLOT_CNT_W-1:0] CNT_MAX = SLOT_CNT_W'((1 << CNT_W) - 1);

   slot_t r_tab [NSLOT];
   logic  r_err;

   logic                 w_hit, w_free, w_ret_ok;
   logic [OUT_ID_W-1:0]  w_hit_idx, w_free_idx;
   logic [SLOT_ID_W-1:0] w_req_id_x;
   logic [NSLOT-1:0]     w_inc, w_dec;

   assign w_req_id_x = SLOT_ID_W'(i_req_id);

   // Descending scan so the lowest-index match/free slot wins.
   always_comb begin
      w_hit      = 1'b0;
      w_free     = 1'b0;
      w_hit_idx  = '0;
      w_free_idx = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (r_tab[i].valid && (r_tab[i].in_id == w_req_id_x)) begin
            w_hit     = 1'b1;
            w_hit_idx = OUT_ID_W'(i);
         end
         if (!r_tab[i].valid) begin
            w_free     = 1'b1;
            w_free_idx = OUT_ID_W'(i);
         end
      end
   end

   assign o_req_slot = w_hit ? w_hit_idx : w_free_idx;
   assign o_req_can  = w_hit ? (r_tab[w_hit_idx].cnt != CNT_MAX) : w_free;
   assign w_ret_ok   = i_ret && (r_tab[i_rsp_slot].cnt != '0);
   assign o_rsp_id   = r_tab[i_rsp_slot].in_id[IN_ID_W-1:0];
   assign o_err      = r_err;

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int i = 0; i < NSLOT; i++) begin
         w_inc[i] = i_req_fire && (o_req_slot == OUT_ID_W'(i));
         w_dec[i] = w_ret_ok && (i_rsp_slot == OUT_ID_W'(i));
      end
   end

   always_ff @(posedge i_core_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_err <= 1'b0;
         for (int i = 0; i < NSLOT; i++) r_tab[i] <= '0;
      end else begin
         if (i_ret && !w_ret_ok) r_err <= 1'b1;
         // Issue and retire on the same slot cancel out.
         for (int i = 0; i < NSLOT; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               if (r_tab[i].valid) r_tab[i].cnt <= r_tab[i].cnt + SLOT_CNT_W'(1);
               else r_tab[i] <= '{valid: 1'b1, in_id: w_req_id_x, cnt: SLOT_CNT_W'(1)};
            end else if (w_dec[i] && !w_inc[i]) begin
               r_tab[i].cnt <= r_tab[i].cnt - SLOT_CNT_W'(1);
               if (r_tab[i].cnt == SLOT_CNT_W'(1)) r_tab[i].valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/axi4_id_compactor.sv
// Wide-to-narrow AXI4 ID remapper for AR/R and AW/B; all paths combinational (0 cycles).
// Requests stall (ready/valid low) when no slot can take the ID; responses pass ready straight through.
module axi4_id_compactor
   import axi4_id_compactor_pkg::*;
#(
   parameter int IN_ID_W  = 8,
   parameter int OUT_ID_W = 2,
   parameter int CNT_W    = 4,
   parameter int AR_PL_W  = 48,
   parameter int AW_PL_W  = 48,
   parameter int R_PL_W   = 34,
   parameter int B_PL_W   = 2
) (
   input  logic                i_core_clk,
   input  logic                i_arst_n,
   input  logic                i_s_ar_valid,
   output logic                o_s_ar_ready,
   input  logic [IN_ID_W-1:0]  i_s_ar_id,
   input  logic [AR_PL_W-1:0]  i_s_ar_pl,
   output logic                o_m_ar_valid,
   input  logic                i_m_ar_ready,
   output logic [OUT_ID_W-1:0] o_m_ar_id,
   output logic [AR_PL_W-1:0]  o_m_ar_pl,
   input  logic                i_m_r_valid,
   output logic                o_m_r_ready,
   input  logic [OUT_ID_W-1:0] i_m_r_id,
   input  logic                i_m_r_last,
   input  logic [R_PL_W-1:0]   i_m_r_pl,
   output logic                o_s_r_valid,
   input  logic                i_s_r_ready,
   output logic [IN_ID_W-1:0]  o_s_r_id,
   output logic                o_s_r_last,
   output logic [R_PL_W-1:0]   o_s_r_pl,
   input  logic                i_s_aw_valid,
   output logic                o_s_aw_ready,
   input  logic [IN_ID_W-1:0]  i_s_aw_id,
   input  logic [AW_PL_W-1:0]  i_s_aw_pl,
   output logic                o_m_aw_valid,
   input  logic                i_m_aw_ready,
   output logic [OUT_ID_W-1:0] o_m_aw_id,
   output logic [AW_PL_W-1:0]  o_m_aw_pl,
   input  logic                i_m_b_valid,
   output logic                o_m_b_ready,
   input  logic [OUT_ID_W-1:0] i_m_b_id,
   input  logic [B_PL_W-1:0]   i_m_b_pl,
   output logic                o_s_b_valid,
   input  logic                i_s_b_ready,
   output logic [IN_ID_W-1:0]  o_s_b_id,
   output logic [B_PL_W-1:0]   o_s_b_pl,
   output logic                o_err
);

   logic                w_ar_can, w_aw_can, w_ar_fire, w_aw_fire, w_r_ret, w_b_ret;
   logic                w_ar_err, w_aw_err;
   logic [OUT_ID_W-1:0] w_ar_slot, w_aw_slot;

   // Handshake outputs are gated by reset so nothing moves while it is held.
   assign o_m_ar_valid = i_arst_n & i_s_ar_valid & w_ar_can;
   assign o_s_ar_ready = i_arst_n & i_m_ar_ready & w_ar_can;
   assign o_m_ar_id    = w_ar_slot;
   assign o_m_ar_pl    = i_s_ar_pl;
   assign w_ar_fire    = o_m_ar_valid & i_m_ar_ready;

   assign o_s_r_valid  = i_arst_n & i_m_r_valid;
   assign o_m_r_ready  = i_arst_n & i_s_r_ready;
   assign o_s_r_last   = i_m_r_last;
   assign o_s_r_pl     = i_m_r_pl;
   assign w_r_ret      = o_s_r_valid & i_s_r_ready & i_m_r_last;

   assign o_m_aw_valid = i_arst_n & i_s_aw_valid & w_aw_can;
   assign o_s_aw_ready = i_arst_n & i_m_aw_ready & w_aw_can;
   assign o_m_aw_id    = w_aw_slot;
   assign o_m_aw_pl    = i_s_aw_pl;
   assign w_aw_fire    = o_m_aw_valid & i_m_aw_ready;

   assign o_s_b_valid  = i_arst_n & i_m_b_valid;
   assign o_m_b_ready  = i_arst_n & i_s_b_ready;
   assign o_s_b_pl     = i_m_b_pl;
   assign w_b_ret      = o_s_b_valid & i_s_b_ready;

   assign o_err = w_ar_err | w_aw_err;

   axi4_id_map_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .CNT_W(CNT_W)) u_rd_tab (
      .i_core_clk (i_core_clk),
      .i_arst_n   (i_arst_n),
      .i_req_fire (w_ar_fire),
      .i_req_id   (i_s_ar_id),
      .o_req_can  (w_ar_can),
      .o_req_slot (w_ar_slot),
      .i_ret      (w_r_ret),
      .i_rsp_slot (i_m_r_id),
      .o_rsp_id   (o_s_r_id),
      .o_err      (w_ar_err)
   );

   axi4_id_map_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .CNT_W(CNT_W)) u_wr_tab (
      .i_core_clk (i_core_clk),
      .i_arst_n   (i_arst_n),
      .i_req_fire (w_aw_fire),
      .i_req_id   (i_s_aw_id),
      .o_req_can  (w_aw_can),
      .o_req_slot (w_aw_slot),
      .i_ret      (w_b_ret),
      .i_rsp_slot (i_m_b_id),
      .o_rsp_id   (o_s_b_id),
      .o_err      (w_aw_err)
   );

endmodule

// File: tb/tb_axi4_id_compactor.sv
// Randomized + directed bench for axi4_id_compactor against a per-slot binding/outstanding model.
module tb_axi4_id_compactor;

   localparam int MAXO = 15;

   logic clk, rst_n;
   logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
   logic [7:0] s_ar_id;  logic [47:0] s_ar_pl, m_ar_pl;  logic [1:0] m_ar_id;
   logic m_r_valid, m_r_ready, m_r_last, s_r_valid, s_r_ready, s_r_last;
   logic [1:0] m_r_id;  logic [33:0] m_r_pl, s_r_pl;  logic [7:0] s_r_id;
   logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
   logic [7:0] s_aw_id;  logic [47:0] s_aw_pl, m_aw_pl;  logic [1:0] m_aw_id;
   logic m_b_valid, m_b_ready, s_b_valid, s_b_ready;
   logic [1:0] m_b_id, m_b_pl, s_b_pl;  logic [7:0] s_b_id;
   logic err;

   int n_chk = 0, n_err = 0;

   // Model: per channel, per slot: number outstanding and the ID it was last bound to.
   int m_cnt [2][4];
   int m_bid [2][4];
   bit m_err;

   bit f_ar, f_aw, rt_r, rt_b;
   int sl_ar, sl_aw;
   int pool [6] = '{8'h01, 8'h22, 8'h5A, 8'h7F, 8'h80, 8'hFF};

   axi4_id_compactor dut (
      .i_core_clk(clk), .i_arst_n(rst_n),
      .i_s_ar_valid(s_ar_valid), .o_s_ar_ready(s_ar_ready), .i_s_ar_id(s_ar_id), .i_s_ar_pl(s_ar_pl),
      .o_m_ar_valid(m_ar_valid), .i_m_ar_ready(m_ar_ready), .o_m_ar_id(m_ar_id), .o_m_ar_pl(m_ar_pl),
      .i_m_r_valid(m_r_valid), .o_m_r_ready(m_r_ready), .i_m_r_id(m_r_id), .i_m_r_last(m_r_last),
      .i_m_r_pl(m_r_pl), .o_s_r_valid(s_r_valid), .i_s_r_ready(s_r_ready), .o_s_r_id(s_r_id),
      .o_s_r_last(s_r_last), .o_s_r_pl(s_r_pl),
      .i_s_aw_valid(s_aw_valid), .o_s_aw_ready(s_aw_ready), .i_s_aw_id(s_aw_id), .i_s_aw_pl(s_aw_pl),
      .o_m_aw_valid(m_aw_valid), .i_m_aw_ready(m_aw_ready), .o_m_aw_id(m_aw_id), .o_m_aw_pl(m_aw_pl),
      .i_m_b_valid(m_b_valid), .o_m_b_ready(m_b_ready), .i_m_b_id(m_b_id), .i_m_b_pl(m_b_pl),
      .o_s_b_valid(s_b_valid), .i_s_b_ready(s_b_ready), .o_s_b_id(s_b_id), .o_s_b_pl(s_b_pl),
      .o_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < 2; c++)
         for (int j = 0; j < 4; j++) begin
            m_cnt[c][j] = 0;
            m_bid[c][j] = 0;
         end
      m_err = 1'b0;
   endfunction

   // An ID already in flight keeps its slot; otherwise the lowest unbound slot is taken.
   function automatic void predict(input int ch, input int id, output bit can, output int slot);
      can = 1'b0;
      slot = 0;
      for (int j = 0; j < 4; j++)
         if (m_cnt[ch][j] > 0 && m_bid[ch][j] == id) begin
            can = (m_cnt[ch][j] < MAXO);
            slot = j;
            return;
         end
      for (int j = 0; j < 4; j++)
         if (m_cnt[ch][j] == 0) begin
            can = 1'b1;
            slot = j;
            return;
         end
   endfunction

   function automatic void update(input int ch, input bit req, input int id, input int slot,
                                  input bit ret, input int rs);
      bit ok;
      ok = (m_cnt[ch][rs] > 0);
      if (ret && !ok) m_err = 1'b1;
      if (req) begin
         if (m_cnt[ch][slot] == 0) m_bid[ch][slot] = id;
         m_cnt[ch][slot]++;
      end
      if (ret && ok) m_cnt[ch][rs]--;
   endfunction

   task automatic idle();
      s_ar_valid = 0; m_r_valid = 0; s_aw_valid = 0; m_b_valid = 0;
      m_ar_ready = 1; s_r_ready = 1; m_aw_ready = 1; s_b_ready = 1;
      m_r_last = 1;
   endtask

   task automatic settle_check();
      bit c0, c1;
      int q0, q1;
      @(negedge clk);
      predict(0, int'(s_ar_id), c0, q0);
      predict(1, int'(s_aw_id), c1, q1);
      check("ar_mvld", 64'(m_ar_valid), 64'(s_ar_valid & c0));
      check("ar_srdy", 64'(s_ar_ready), 64'(m_ar_ready & c0));
      if (s_ar_valid && c0) check("ar_mid", 64'(m_ar_id), 64'(q0));
      check("ar_pl", 64'(m_ar_pl), 64'(s_ar_pl));
      check("r_svld", 64'(s_r_valid), 64'(m_r_valid));
      check("r_mrdy", 64'(m_r_ready), 64'(s_r_ready));
      if (m_r_valid) begin
         check("r_sid", 64'(s_r_id), 64'(m_bid[0][m_r_id]));
         check("r_last", 64'(s_r_last), 64'(m_r_last));
         check("r_pl", 64'(s_r_pl), 64'(m_r_pl));
      end
      check("aw_mvld", 64'(m_aw_valid), 64'(s_aw_valid & c1));
      check("aw_srdy", 64'(s_aw_ready), 64'(m_aw_ready & c1));
      if (s_aw_valid && c1) check("aw_mid", 64'(m_aw_id), 64'(q1));
      check("aw_pl", 64'(m_aw_pl), 64'(s_aw_pl));
      check("b_svld", 64'(s_b_valid), 64'(m_b_valid));
      check("b_mrdy", 64'(m_b_ready), 64'(s_b_ready));
      if (m_b_valid) begin
         check("b_sid", 64'(s_b_id), 64'(m_bid[1][m_b_id]));
         check("b_pl", 64'(s_b_pl), 64'(m_b_pl));
      end
      check("err", 64'(err), 64'(m_err));
      f_ar = s_ar_valid & m_ar_ready & c0;  sl_ar = q0;
      f_aw = s_aw_valid & m_aw_ready & c1;  sl_aw = q1;
      rt_r = m_r_valid & s_r_ready & m_r_last;
      rt_b = m_b_valid & s_b_ready;
   endtask

   task automatic commit();
      @(posedge clk);
      update(0, f_ar, int'(s_ar_id), sl_ar, rt_r, int'(m_r_id));
      update(1, f_aw, int'(s_aw_id), sl_aw, rt_b, int'(m_b_id));
      #1;
   endtask

   task automatic step();
      settle_check();
      commit();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ar_srdy"}, 64'(s_ar_ready), 64'(0));
      check({tag, "_ar_mvld"}, 64'(m_ar_valid), 64'(0));
      check({tag, "_r_mrdy"},  64'(m_r_ready),  64'(0));
      check({tag, "_r_svld"},  64'(s_r_valid),  64'(0));
      check({tag, "_aw_srdy"}, 64'(s_aw_ready), 64'(0));
      check({tag, "_aw_mvld"}, 64'(m_aw_valid), 64'(0));
      check({tag, "_b_mrdy"},  64'(m_b_ready),  64'(0));
      check({tag, "_b_svld"},  64'(s_b_valid),  64'(0));
      check({tag, "_err"},     64'(err),        64'(0));
   endtask

   task automatic rand_rsp(input int ch, input bit allow_bad, output logic vld, output logic [1:0] slot);
      int q[$];
      for (int j = 0; j < 4; j++) if (m_cnt[ch][j] > 0) q.push_back(j);
      vld = 1'b0;
      slot = 2'($urandom_range(0, 3));
      if (q.size() > 0 && $urandom_range(0, 99) < 60) begin
         vld = 1'b1;
         slot = 2'(q[$urandom_range(0, q.size() - 1)]);
      end else if (allow_bad && $urandom_range(0, 99) < 3) begin
         vld = 1'b1;
      end
   endtask

   task automatic rand_cycles(input int n, input bit allow_bad);
      for (int k = 0; k < n; k++) begin
         s_ar_valid = ($urandom_range(0, 99) < 70);
         s_ar_id    = 8'(pool[$urandom_range(0, 5)]);
         s_ar_pl    = 48'({$urandom, $urandom});
         m_ar_ready = ($urandom_range(0, 99) < 75);
         rand_rsp(0, allow_bad, m_r_valid, m_r_id);
         m_r_last   = 1'($urandom_range(0, 1));
         m_r_pl     = 34'({$urandom, $urandom});
         s_r_ready  = ($urandom_range(0, 99) < 80);
         s_aw_valid = ($urandom_range(0, 99) < 70);
         s_aw_id    = 8'(pool[$urandom_range(0, 5)]);
         s_aw_pl    = 48'({$urandom, $urandom});
         m_aw_ready = ($urandom_range(0, 99) < 75);
         rand_rsp(1, allow_bad, m_b_valid, m_b_id);
         m_b_pl     = 2'($urandom);
         s_b_ready  = ($urandom_range(0, 99) < 80);
         step();
      end
   endtask

   initial begin
      model_reset();
      s_ar_id = 0; s_ar_pl = 0; m_r_id = 0; m_r_pl = 0;
      s_aw_id = 0; s_aw_pl = 0; m_b_id = 0; m_b_pl = 0;
      idle();
      s_ar_valid = 1; m_r_valid = 1; s_aw_valid = 1; m_b_valid = 1;
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("rst0");
      idle();
      rst_n = 1;
      @(posedge clk); #1;

      // AR 0x5A, 0x5A, 0x13 then responses restore the wide IDs.
      s_ar_valid = 1;
      s_ar_id = 8'h5A; settle_check(); check("t1_slot_a", 64'(m_ar_id), 64'(0)); commit();
      s_ar_id = 8'h5A; settle_check(); check("t1_slot_b", 64'(m_ar_id), 64'(0)); commit();
      s_ar_id = 8'h13; settle_check(); check("t1_slot_c", 64'(m_ar_id), 64'(1)); commit();
      s_ar_valid = 0; m_r_valid = 1; m_r_last = 1;
      m_r_id = 0; settle_check(); check("t1_rid_a", 64'(s_r_id), 64'(8'h5A)); commit();
      m_r_id = 0; settle_check(); check("t1_rid_b", 64'(s_r_id), 64'(8'h5A)); commit();
      m_r_id = 1; settle_check(); check("t1_rid_c", 64'(s_r_id), 64'(8'h13)); commit();
      m_r_valid = 0; s_ar_valid = 1; s_ar_id = 8'h66;
      settle_check(); check("t1_reuse", 64'(m_ar_id), 64'(0)); commit();
      s_ar_valid = 0; m_r_valid = 1; m_r_id = 0; step();
      idle();

      // Fill all four AW slots; 0x20 waits until the B on slot 2 is registered.
      s_aw_valid = 1;
      for (int i = 0; i < 4; i++) begin
         s_aw_id = 8'(8'h10 + i);
         settle_check(); check("t2_fill", 64'(m_aw_id), 64'(i)); commit();
      end
      s_aw_id = 8'h20;
      settle_check(); check("t2_full", 64'(s_aw_ready), 64'(0)); commit();
      m_b_valid = 1; m_b_id = 2;
      settle_check();
      check("t2_same_cyc", 64'(s_aw_ready), 64'(0));
      check("t2_bid", 64'(s_b_id), 64'(8'h12));
      commit();
      m_b_valid = 0;
      settle_check();
      check("t2_next_rdy", 64'(s_aw_ready), 64'(1));
      check("t2_next_slot", 64'(m_aw_id), 64'(2));
      commit();
      s_aw_valid = 0; m_b_valid = 1;
      for (int i = 0; i < 4; i++) begin
         m_b_id = 2'(i);
         step();
      end
      idle();

      // Same ID to the per-slot limit, then one retire frees a count a cycle later.
      s_ar_valid = 1; s_ar_id = 8'h07;
      repeat (15) step();
      settle_check(); check("t3_max_rdy", 64'(s_ar_ready), 64'(0)); commit();
      m_r_valid = 1; m_r_id = 0; m_r_last = 1;
      settle_check(); check("t3_ret_cyc", 64'(s_ar_ready), 64'(0)); commit();
      m_r_valid = 0;
      settle_check(); check("t3_after", 64'(s_ar_ready), 64'(1)); commit();
      s_ar_valid = 0; m_r_valid = 1;
      repeat (14) step();
      // Slot 0 holds one; issue + retire together keeps it bound.
      s_ar_valid = 1;
      settle_check(); check("t4_rdy", 64'(s_ar_ready), 64'(1)); commit();
      m_r_valid = 0; s_ar_id = 8'h08;
      settle_check(); check("t4_kept", 64'(m_ar_id), 64'(1)); commit();
      s_ar_valid = 0; m_r_valid = 1;
      m_r_id = 0; step();
      m_r_id = 1; step();
      idle();

      // B on an idle slot: sticky error, stale ID forwarded.
      m_b_valid = 1; m_b_id = 3;
      settle_check(); check("t5_stale", 64'(s_b_id), 64'(8'h13)); commit();
      m_b_valid = 0;
      settle_check(); check("t5_err", 64'(err), 64'(1)); commit();
      step();

      rand_cycles(400, 1'b1);

      // Reset in the middle of traffic.
      s_ar_valid = 1; m_ar_ready = 1; m_r_valid = 1; s_r_ready = 1;
      s_aw_valid = 1; m_aw_ready = 1; m_b_valid = 1; s_b_ready = 1;
      rst_n = 0;
      #1;
      check_quiet("rst1");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_quiet("rst2");
      idle();
      rst_n = 1;
      @(posedge clk); #1;

      rand_cycles(300, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
